// File: rtl/lsu_pkg.sv
// lsu_pkg: RV32I load/store funct3 codes, error codes and the unit's state type.
package lsu_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_FAULT    = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd3;
    typedef enum logic {IDLE, LOAD_WAIT} state_t;
endpackage

// File: rtl/load_align.sv
// load_align: picks the byte/half at a byte offset of a memory word and sign/zero extends it.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [31:0] w_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    assign w_sh   = i_word >> {i_offset, 3'b000};
    assign w_byte = w_sh[7:0];
    assign w_half = w_sh[15:0];
    always_comb begin
        o_data = i_funct3 == F3_LB  ? {{24{w_byte[7]}}, w_byte} :
                 i_funct3 == F3_LH  ? {{16{w_half[15]}}, w_half} :
                 i_funct3 == F3_LBU ? {24'd0, w_byte} :
                 i_funct3 == F3_LHU ? {16'd0, w_half} : i_word;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store front end for a word-organised, 1-cycle-read data memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADR_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [2:0]       funct3_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic             ready_o,
    output logic             rsp_valid_o,
    output logic [31:0]      rdata_o,
    output logic [1:0]       err_o,
    output logic             mem_en_o,
    output logic [3:0]       mem_we_o,
    output logic [ADR_W-1:0] mem_adr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i
);
    state_t      r_state;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic        r_rsp;
    logic [31:0] r_rdata;
    logic [1:0]  r_err;
    logic        w_acc, w_is_h, w_is_w, w_illegal, w_mis, w_oor;
    logic [1:0]  w_err;
    logic [3:0]  w_mask;
    logic [31:0] w_off, w_ext;

    assign ready_o   = !rst && r_state == IDLE;
    assign w_acc     = req_i && ready_o;
    assign w_is_h    = funct3_i[1:0] == 2'b01;
    assign w_is_w    = funct3_i[1:0] == 2'b10;
    assign w_illegal = we_i ? funct3_i > F3_SW : (funct3_i == 3'd3 || funct3_i >= 3'd6);
    assign w_mis     = (w_is_h && addr_i[0]) || (w_is_w && addr_i[1:0] != 2'b00);
    assign w_off     = addr_i - BASE_ADDR;
    // Unsigned subtraction wraps addresses below BASE_ADDR above the window too.
    assign w_oor     = w_off >= (32'd4 << ADR_W);
    assign w_err     = w_illegal ? ERR_ILLEGAL : w_mis ? ERR_MISALIGN : w_oor ? ERR_FAULT : ERR_NONE;
    assign w_mask    = w_is_w ? 4'b1111 : w_is_h ? 4'b0011 << addr_i[1:0] : 4'b0001 << addr_i[1:0];

    assign mem_en_o    = w_acc && w_err == ERR_NONE;
    assign mem_we_o    = mem_en_o && we_i ? w_mask : 4'b0000;
    assign mem_adr_o   = w_off[ADR_W+1:2];
    assign mem_wdata_o = w_is_w ? wdata_i : w_is_h ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};

    assign rsp_valid_o = r_rsp;
    assign rdata_o     = r_rdata;
    assign err_o       = r_err;

    load_align u_align (
        .i_word   (mem_rdata_i),
        .i_offset (r_off),
        .i_funct3 (r_f3),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rsp   <= 1'b0;
            r_rdata <= '0;
            r_err   <= ERR_NONE;
            r_f3    <= '0;
            r_off   <= '0;
        end else begin
            r_rsp <= 1'b0;
            case (r_state)
                IDLE: if (w_acc) begin
                    if (w_err != ERR_NONE || we_i) begin
                        r_rsp   <= 1'b1;
                        r_err   <= w_err;
                        r_rdata <= '0;
                    end else begin
                        r_f3    <= funct3_i;
                        r_off   <= addr_i[1:0];
                        r_state <= LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    r_rsp   <= 1'b1;
                    r_err   <= ERR_NONE;
                    r_rdata <= w_ext;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: vector table, hand sequences and random traffic against a byte-array reference.
module tb_load_store_unit;
    logic        clk = 0, rst = 1, init = 1;
    logic        req_i = 0, we_i = 0;
    logic [2:0]  funct3_i = 0;
    logic [31:0] addr_i = 0, wdata_i = 0;
    logic        ready_o, rsp_valid_o, mem_en_o;
    logic [31:0] rdata_o, mem_wdata_o, mem_rdata_i;
    logic [1:0]  err_o;
    logic [3:0]  mem_we_o;
    logic [11:0] mem_adr_o;

    int n_chk = 0, n_err = 0;
    logic [31:0] mem [4096];
    logic [7:0]  model [16384];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        logic [1:0]  err;
        logic [3:0]  wem;
        logic [11:0] adr;
        logic [31:0] mwd, rd;
    } vec_t;
    vec_t v[15];

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .rsp_valid_o(rsp_valid_o),
        .rdata_o(rdata_o), .err_o(err_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_adr_o(mem_adr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= (i == 4) ? 32'h80F17F01 : 32'h0;
        end else if (mem_en_o) begin
            for (int i = 0; i < 4; i++) if (mem_we_o[i]) mem[mem_adr_o][8*i +: 8] <= mem_wdata_o[8*i +: 8];
            mem_rdata_i <= mem[mem_adr_o];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    endfunction

    // Reference: byte-addressed memory plus the access rules, no knowledge of the unit's internals.
    function automatic vec_t ref_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        vec_t r;
        int sz = size_of(f3);
        logic [31:0] val = 0;
        r.we = we; r.f3 = f3; r.addr = a; r.wdata = d; r.wem = 0; r.mwd = 0; r.rd = 0;
        r.adr = 12'((a / 4) % 4096);
        if (we ? f3 > 2 : (f3 == 3 || f3 >= 6)) r.err = 3;
        else if (a % sz != 0) r.err = 1;
        else if (a >= 16384) r.err = 2;
        else r.err = 0;
        if (r.err == 0 && we) begin
            for (int i = 0; i < sz; i++) r.wem[a % 4 + i] = 1'b1;
            r.mwd = sz == 1 ? {4{d[7:0]}} : sz == 2 ? {2{d[15:0]}} : d;
        end
        if (r.err == 0 && !we) begin
            for (int i = 0; i < sz; i++) val = val | (32'(model[a + i]) << (8 * i));
            if (!f3[2] && sz < 4 && val[8*sz-1]) val = val | (32'hFFFFFFFF << (8 * sz));
            r.rd = val;
        end
        return r;
    endfunction

    task automatic issue(input vec_t x, input bit chk_mem);
        int lat = 1;
        int sz = size_of(x.f3);
        bit ld = !x.we && x.err == 0;
        @(negedge clk);
        req_i = 1; we_i = x.we; funct3_i = x.f3; addr_i = x.addr; wdata_i = x.wdata;
        #1;
        chk("mem_en", 32'(mem_en_o), 32'(x.err == 0));
        chk("mem_we", 32'(mem_we_o), 32'(x.wem));
        if (chk_mem && x.err == 0) chk("mem_adr", 32'(mem_adr_o), 32'(x.adr));
        if (chk_mem && x.err == 0 && x.we) chk("mem_wdata", mem_wdata_o, x.mwd);
        @(negedge clk);
        req_i = 0;
        if (ld) chk("ready_wait", 32'(ready_o), 32'd0);
        while (!rsp_valid_o && lat < 4) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), ld ? 32'd2 : 32'd1);
        chk("err", 32'(err_o), 32'(x.err));
        chk("rdata", rdata_o, x.rd);
        if (x.we && x.err == 0)
            for (int i = 0; i < sz; i++) model[x.addr + i] = 8'(x.wdata >> (8 * i));
    endtask

    initial begin
        vec_t r;
        for (int i = 0; i < 16384; i++) model[i] = 8'h00;
        {model[19], model[18], model[17], model[16]} = 32'h80F17F01;
        v[0]  = '{1, 3'd0, 32'h6,    32'hAB,       0, 4'b0100, 12'd1, 32'hABABABAB, 0};
        v[1]  = '{1, 3'd1, 32'h2,    32'h1234,     0, 4'b1100, 12'd0, 32'h12341234, 0};
        v[2]  = '{1, 3'd2, 32'h0,    32'hDEADBEEF, 0, 4'b1111, 12'd0, 32'hDEADBEEF, 0};
        v[3]  = '{0, 3'd0, 32'h13,   0, 0, 4'b0000, 12'd4, 0, 32'hFFFFFF80};
        v[4]  = '{0, 3'd4, 32'h13,   0, 0, 4'b0000, 12'd4, 0, 32'h00000080};
        v[5]  = '{0, 3'd1, 32'h12,   0, 0, 4'b0000, 12'd4, 0, 32'hFFFF80F1};
        v[6]  = '{0, 3'd5, 32'h10,   0, 0, 4'b0000, 12'd4, 0, 32'h00007F01};
        v[7]  = '{0, 3'd2, 32'h10,   0, 0, 4'b0000, 12'd4, 0, 32'h80F17F01};
        v[8]  = '{0, 3'd2, 32'h2,    0, 1, 4'b0000, 12'd0, 0, 0};
        v[9]  = '{1, 3'd2, 32'h4000, 0, 2, 4'b0000, 12'd0, 0, 0};
        v[10] = '{0, 3'd3, 32'h0,    0, 3, 4'b0000, 12'd0, 0, 0};
        v[11] = '{0, 3'd2, 32'h4002, 0, 1, 4'b0000, 12'd0, 0, 0};
        v[12] = '{0, 3'd2, 32'h0,    0, 0, 4'b0000, 12'd0, 0, 32'hDEADBEEF};
        v[13] = '{0, 3'd2, 32'h4,    0, 0, 4'b0000, 12'd1, 0, 32'h00AB0000};
        v[14] = '{0, 3'd1, 32'h6,    0, 0, 4'b0000, 12'd1, 0, 32'h000000AB};

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", 32'(ready_o), 0);
            chk("rst_rsp", 32'(rsp_valid_o), 0);
            chk("rst_rdata", rdata_o, 0);
            chk("rst_mem_en", 32'(mem_en_o), 0);
        end
        init = 0; rst = 0;
        @(negedge clk);
        chk("idle_ready", 32'(ready_o), 1);

        foreach (v[i]) issue(v[i], 1);

        // Back-to-back stores: second accepted in the cycle the first responds.
        @(negedge clk);
        req_i = 1; we_i = 1; funct3_i = 3'd0; addr_i = 32'h21; wdata_i = 32'h5A;
        @(negedge clk);
        chk("b2b_rsp1", 32'(rsp_valid_o), 1);
        funct3_i = 3'd1; addr_i = 32'h22; wdata_i = 32'hC3C3;
        #1;
        chk("b2b_en2", 32'(mem_en_o), 1);
        chk("b2b_we2", 32'(mem_we_o), 32'b1100);
        @(negedge clk);
        req_i = 0;
        chk("b2b_rsp2", 32'(rsp_valid_o), 1);
        model[33] = 8'h5A; model[34] = 8'hC3; model[35] = 8'hC3;
        issue(ref_req(0, 3'd2, 32'h20, 0), 1);

        // Reset during LOAD_WAIT aborts the load silently.
        @(negedge clk);
        req_i = 1; we_i = 0; funct3_i = 3'd2; addr_i = 32'h10;
        @(negedge clk);
        req_i = 0; rst = 1;
        @(negedge clk);
        chk("abort_rsp", 32'(rsp_valid_o), 0);
        chk("abort_ready_rst", 32'(ready_o), 0);
        rst = 0;
        #1;
        chk("abort_ready", 32'(ready_o), 1);
        @(negedge clk);
        chk("abort_rsp2", 32'(rsp_valid_o), 0);

        // Request held through LOAD_WAIT is ignored; a new one is taken at T+2.
        @(negedge clk);
        req_i = 1; we_i = 0; funct3_i = 3'd2; addr_i = 32'h10;
        @(negedge clk);
        we_i = 1; addr_i = 32'h24; wdata_i = 32'hFFFFFFFF;
        #1;
        chk("hold_en", 32'(mem_en_o), 0);
        chk("hold_ready", 32'(ready_o), 0);
        @(negedge clk);
        chk("hold_rsp", 32'(rsp_valid_o), 1);
        chk("hold_rdata", rdata_o, 32'h80F17F01);
        we_i = 0; funct3_i = 3'd4; addr_i = 32'h13;
        #1;
        chk("fresh_en", 32'(mem_en_o), 1);
        @(negedge clk);
        req_i = 0;
        @(negedge clk);
        chk("fresh_rsp", 32'(rsp_valid_o), 1);
        chk("fresh_rdata", rdata_o, 32'h80);
        issue(ref_req(0, 3'd2, 32'h24, 0), 1);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a = $urandom_range(0, 127);
            if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 1) ? 32'h4000 + $urandom_range(0, 15) : $urandom;
            r = ref_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
            issue(r, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the word-organised data memory (4096 x 32-bit, 1-cycle synchronous read, per-byte write enables).
- Translates RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into a word address, a byte-enable mask and lane-shifted store data.
- Captures the memory read one cycle later and returns sign- or zero-extended load data through a valid handshake.
- Flags misaligned, out-of-range and illegal-funct3 accesses without touching memory.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of data-memory word 0; the window is BASE_ADDR .. BASE_ADDR+16383.
- ADR_W, 12, word-address width driven to memory.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_i  input  1  request valid; accepted when req_i & ready_o.
- we_i  input  1  1 = store, 0 = load.
- funct3_i  input  3  RV32I width/sign code.
- addr_i  input  32  byte address.
- wdata_i  input  32  store data, right-aligned.
- ready_o  output  1  unit can accept a request this cycle.
- rsp_valid_o  output  1  one-cycle completion pulse.
- rdata_o  output  32  extended load data, valid with rsp_valid_o.
- err_o  output  2  0 none, 1 misaligned, 2 access fault, 3 illegal funct3; valid with rsp_valid_o.
- mem_en_o  output  1  memory enable.
- mem_we_o  output  4  byte write enables.
- mem_adr_o  output  ADR_W  word address = (addr_i-BASE_ADDR)[13:2].
- mem_wdata_o  output  32  lane-replicated store data.
- mem_rdata_i  input  32  memory read data, valid the cycle after mem_en_o.

Behaviour:
- Reset: state IDLE; rsp_valid_o=0, rdata_o=0, err_o=0. ready_o, mem_en_o and mem_we_o are forced to 0 while rst is high.
- FSM states:
  - IDLE: ready_o=1.
  - LOAD_WAIT: ready_o=0; memory data arrives this cycle.
- Memory signals are combinational from the request and are driven only in the accept cycle when the check result is 0. Otherwise mem_en_o=0 and mem_we_o=0.
- Checks, in priority order:
  - Illegal funct3: loads 3/6/7, stores >=3 -> err 3.
  - Misaligned: H with addr[0]=1, W with addr[1:0]!=0 -> err 1.
  - Address outside the window -> err 2.
- Store accepted at cycle T:
  - mem_en_o=1; mem_we_o = SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111.
  - mem_wdata_o = SB {4{b}}, SH {2{h}}, SW word.
  - rsp_valid_o=1, err 0, rdata_o=0 at T+1. State stays IDLE, so back-to-back stores run one per cycle.
- Load accepted at cycle T:
  - mem_en_o=1, mem_we_o=0; register funct3 and addr[1:0]; go to LOAD_WAIT.
  - At T+1, select the byte/half at the registered offset, sign-extend (LB/LH) or zero-extend (LBU/LHU), and register it into rdata_o.
  - At T+2: rsp_valid_o=1, state IDLE, ready_o=1. A new request may be accepted in the same T+2 cycle.
- Error request at T: no memory activity; rsp_valid_o=1 with err_o at T+1, rdata_o=0; state stays IDLE.
- rsp_valid_o is a single-cycle pulse with no back-pressure. rdata_o/err_o hold until the next response.
- req_i while ready_o=0 is ignored and not queued.
- rst asserted in LOAD_WAIT: return to IDLE; no response is ever produced for the aborted load.
- Memory reads during stores: the unit ignores them.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_LB..F3_SW.
  - Error-code constants ERR_NONE/ERR_MISALIGN/ERR_FAULT/ERR_ILLEGAL.
  - The state enum {IDLE, LOAD_WAIT}.
- One combinational sub-module, load_align: inputs word, offset[1:0], funct3; output extended 32-bit value.

Test Plan:
- Reset/idle: rst high 3 cycles -> ready_o=0, rsp_valid_o=0, rdata_o=0, mem_en_o=0. After release -> ready_o=1.
- Store masks: SB addr 0x00000006 data 0xAB -> mem_we_o=0100, mem_adr_o=1, mem_wdata_o=0xABABABAB. SH 0x00000002 0x1234 -> we 1100. SW 0x0 -> we 1111. rsp_valid_o 1 cycle later each; back-to-back issue proven.
- Load extend: word@0x10 preloaded with 0x80F17F01:
  - LB 0x13 -> 0xFFFFFF80.
  - LBU 0x13 -> 0x00000080.
  - LH 0x12 -> 0xFFFF80F1.
  - LHU 0x10 -> 0x00007F01.
  - LW -> 0x80F17F01.
  - Each rsp_valid_o at T+2; ready_o=0 at T+1.
- Errors, each giving mem_en_o=0 and rsp_valid_o at T+1:
  - LW 0x00000002 -> err 1.
  - SW 0x00004000 (BASE 0) -> err 2.
  - funct3=3 load -> err 3.
  - Misaligned and out-of-range together (LW 0x00004002) -> err 1.
- Reset mid-load: LW accepted at T, rst at T+1 -> no rsp_valid_o at T+2; ready_o=1 once rst is low.
- Handshake: req_i held high during LOAD_WAIT with a different address -> ignored. A fresh request at T+2 is accepted while rsp_valid_o is high.
